tdm_demux_12: RTL and testbench
===============================

Name: tdm_demux_12

Overview:
- Receive-side companion of the 2:1 select path: the transmitter time-multiplexes two channels onto one line by toggling select every clock.
- This block de-interleaves that serial stream back into two parallel words, one per channel, and strobes valid once per frame.
- Sits at the far end of the single-wire link, feeding the per-channel consumers (display/LED logic).

Parameters:
WIDTH, 8, bits per channel word; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
din  input  1  interleaved serial data: A bit, B bit, A bit, ... MSB first.
sync  input  1  one-cycle frame marker; high in the same cycle as channel A MSB.
a_out  output  WIDTH  last completed channel A word.
b_out  output  WIDTH  last completed channel B word.
valid  output  1  one-cycle pulse: a_out/b_out just updated.
sel  output  1  slot expected in the current cycle; 0 = A, 1 = B. Mirrors the transmitter's select.
frame_err  output  1  sticky flag: a frame was aborted by an early sync.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; slot counter = 0; shift registers = 0.
  - a_out = 0, b_out = 0, valid = 0, sel = 0, frame_err = 0.
  - Asserting reset mid-frame discards the partial frame; no valid is produced.
- States:
  - IDLE: din is ignored while sync = 0.
  - RUN: capturing a frame.
- Frame timing:
  - One frame = 2*WIDTH consecutive cycles, counted from t0, the cycle in which sync = 1.
  - In cycle t0+k (k = 0..2W-1): even k → A bit (W-1-k/2); odd k → B bit (W-1-(k-1)/2).
  - Bits shift in MSB first.
- Transitions:
  - IDLE → RUN: on an edge with sync = 1; din in that cycle is captured as A MSB.
  - RUN → IDLE: on the edge ending cycle t0+2W-1 (last B bit).
  - On that same edge, a_out and b_out load the full assembled words, including the final bit, and valid = 1 for exactly one cycle (t0+2W).
- Latency: valid and new words are visible one cycle after the last B bit is sampled.
- Back-to-back frames:
  - sync may be high in cycle t0+2W, the same cycle valid is high.
  - The new frame starts with no gap and the completed words are unaffected.
- sel:
  - Combinational from state and counter.
  - In IDLE, sel = 0.
  - In RUN, sel = k[0].
- Early sync (sync = 1 in RUN at any k = 1..2W-1):
  - Current frame aborted; no valid; a_out/b_out hold.
  - frame_err set.
  - That cycle is treated as a new t0: din captured as A MSB, counter restarts, state stays RUN.
- frame_err: stays set until reset.
- sync high in IDLE with no prior frame: normal start, not an error.
- Outputs a_out/b_out hold their value between valid pulses.
- Counter width: clog2(2*WIDTH); no wrap beyond 2W-1 ever occurs.

Test Plan:
- WIDTH=8, reset, then din held 1, sync = 0 for 40 cycles → stays IDLE; valid never pulses; a_out = b_out = 0x00; sel = 0.
- Single frame: sync at t0, A = 0xA5, B = 0x3C interleaved MSB first → valid high in cycle t0+16 only; a_out = 0xA5, b_out = 0x3C; sel toggles 0,1,0,1... during t0..t0+15.
- Back-to-back: frame A=0x12/B=0x34, then sync in cycle t0+16 with A=0xFF/B=0x00 → first valid gives 0x12/0x34; second valid at t0+32 gives 0xFF/0x00; frame_err = 0.
- Early sync: sync at t0, second sync at t0+7, then a complete frame A=0x5A/B=0xC3 → no valid at t0+16; frame_err = 1 from t0+8; valid at t0+23 with 0x5A/0xC3; frame_err remains 1.
- Reset mid-frame: reset asserted at t0+9 for 2 cycles (asynchronously, off-edge) → all outputs 0 immediately; sel = 0; a new clean frame afterwards decodes correctly and frame_err stays 0.
- WIDTH=2 instance: sync with bit sequence 1,0,0,1 → valid at t0+4 with a_out = 2'b10, b_out = 2'b01.

Source files
------------

// File: rtl/tdm_demux_12.sv
// Receive-side de-interleaver for a two-channel TDM serial link.
// Rebuilds channel A/B words MSB first and pulses valid once per completed frame.
module tdm_demux_12 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             valid,
  output logic             sel,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    cnt, cntNext;
  logic [WIDTH-1:0] shA, shB, shANext, shBNext;
  logic [WIDTH-1:0] aNext, bNext;
  logic             validNext, errNext;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    shANext   = shA;
    shBNext   = shB;
    aNext     = a_out;
    bNext     = b_out;
    validNext = 1'b0;
    errNext   = frame_err;
    case (state)
      IDLE: begin
        if (sync) begin
          stateNext = RUN;
          cntNext   = CW'(1);
          shANext   = {shA[WIDTH-2:0], din};
        end
      end
      RUN: begin
        if (sync) begin
          // Early sync restarts the frame in place; stale bits shift out over the new frame.
          errNext = 1'b1;
          cntNext = CW'(1);
          shANext = {shA[WIDTH-2:0], din};
        end else begin
          if (!cnt[0]) shANext = {shA[WIDTH-2:0], din};
          else         shBNext = {shB[WIDTH-2:0], din};
          if (cnt == LAST) begin
            stateNext = IDLE;
            cntNext   = '0;
            aNext     = shA;
            bNext     = shBNext;
            validNext = 1'b1;
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shA       <= '0;
      shB       <= '0;
      a_out     <= '0;
      b_out     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      shA       <= shANext;
      shB       <= shBNext;
      a_out     <= aNext;
      b_out     <= bNext;
      valid     <= validNext;
      frame_err <= errNext;
    end
  end

  always_comb begin
    sel = 1'b0;
    if (state == RUN) sel = cnt[0];
  end

endmodule

// File: tb/tb_tdm_demux_12.sv
// Self-checking bench for tdm_demux_12: WIDTH=8 and WIDTH=2 instances share one stimulus stream
// and are compared every cycle against a frame-level model of the serial protocol.
module tb_tdm_demux_12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       valid8, sel8, err8;
  logic       valid2, sel2, err2;

  int nTests = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  tdm_demux_12 #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .din(din), .sync(sync),
    .a_out(a8), .b_out(b8), .valid(valid8), .sel(sel8), .frame_err(err8)
  );

  tdm_demux_12 #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .din(din), .sync(sync),
    .a_out(a2), .b_out(b2), .valid(valid2), .sel(sel2), .frame_err(err2)
  );

  // Model: collected serial bits of the current frame, words assembled arithmetically at frame end.
  typedef struct {
    bit          run;
    bit          valid;
    bit          err;
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] bits;
  } mst_t;

  mst_t m [2];

  function automatic mst_t mClear();
    mst_t r;
    r.run = 0; r.valid = 0; r.err = 0; r.k = 0;
    r.a = '0; r.b = '0; r.bits = '0;
    return r;
  endfunction

  function automatic logic [15:0] word(input logic [31:0] bits, input int w, input int off);
    logic [15:0] r = '0;
    for (int j = 0; j < w; j++) r = {r[14:0], bits[2*j+off]};
    return r;
  endfunction

  function automatic mst_t mStep(input mst_t s, input int w, input logic sy, input logic d);
    mst_t r = s;
    r.valid = 0;
    if (sy) begin
      if (s.run) r.err = 1;
      r.run = 1;
      r.k = 1;
      r.bits = '0;
      r.bits[0] = d;
    end else if (s.run) begin
      r.bits[s.k] = d;
      if (s.k == 2*w - 1) begin
        r.a = word(r.bits, w, 0);
        r.b = word(r.bits, w, 1);
        r.valid = 1;
        r.run = 0;
        r.k = 0;
      end else begin
        r.k = s.k + 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m[0] <= mClear();
      m[1] <= mClear();
    end else begin
      m[0] <= mStep(m[0], 8, sync, din);
      m[1] <= mStep(m[1], 2, sync, din);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a8", 16'(a8), m[0].a);
    check("b8", 16'(b8), m[0].b);
    check("valid8", 16'(valid8), 16'(m[0].valid));
    check("sel8", 16'(sel8), m[0].run ? 16'(m[0].k % 2) : 16'd0);
    check("err8", 16'(err8), 16'(m[0].err));
    check("a2", 16'(a2), m[1].a);
    check("b2", 16'(b2), m[1].b);
    check("valid2", 16'(valid2), 16'(m[1].valid));
    check("sel2", 16'(sel2), m[1].run ? 16'(m[1].k % 2) : 16'd0);
    check("err2", 16'(err2), 16'(m[1].err));
  end

  task automatic expectOut(input string tag, input int w, input logic [15:0] ea,
                           input logic [15:0] eb, input logic ev, input logic ee);
    int i = (w == 8) ? 0 : 1;
    check({tag, ".a"}, (w == 8) ? 16'(a8) : 16'(a2), ea);
    check({tag, ".b"}, (w == 8) ? 16'(b8) : 16'(b2), eb);
    check({tag, ".valid"}, (w == 8) ? 16'(valid8) : 16'(valid2), 16'(ev));
    check({tag, ".err"}, (w == 8) ? 16'(err8) : 16'(err2), 16'(ee));
    check({tag, ".model_a"}, m[i].a, ea);
    check({tag, ".model_b"}, m[i].b, eb);
    check({tag, ".model_valid"}, 16'(m[i].valid), 16'(ev));
  endtask

  // Drives len cycles of a frame starting with sync; returns at the negedge of cycle t0+len.
  task automatic sendFrame(input logic [15:0] a, input logic [15:0] b, input int w, input int len);
    for (int k = 0; k < len; k++) begin
      sync = (k == 0);
      din  = (k % 2 == 0) ? a[w-1-k/2] : b[w-1-(k-1)/2];
      @(negedge clk);
      if (k + 1 < 2*w) begin
        check("frameSel", (w == 8) ? 16'(sel8) : 16'(sel2), 16'((k + 1) % 2));
        check("frameNoValid", (w == 8) ? 16'(valid8) : 16'(valid2), 16'd0);
      end
    end
    sync = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expectOut("reset", 8, 16'h00, 16'h00, 1'b0, 1'b0);
    check("reset.sel", 16'(sel8), 16'd0);
    reset = 1'b0;

    sync = 1'b0; din = 1'b1;
    repeat (40) @(negedge clk);
    expectOut("idle", 8, 16'h00, 16'h00, 1'b0, 1'b0);
    check("idle.sel", 16'(sel8), 16'd0);

    sendFrame(16'hA5, 16'h3C, 8, 16);
    expectOut("single", 8, 16'hA5, 16'h3C, 1'b1, 1'b0);

    sendFrame(16'h12, 16'h34, 8, 16);
    expectOut("b2b1", 8, 16'h12, 16'h34, 1'b1, 1'b0);
    sendFrame(16'hFF, 16'h00, 8, 16);
    expectOut("b2b2", 8, 16'hFF, 16'h00, 1'b1, 1'b0);

    sendFrame(16'($urandom), 16'($urandom), 8, 8);
    din = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    expectOut("midReset", 8, 16'h00, 16'h00, 1'b0, 1'b0);
    check("midReset.sel", 16'(sel8), 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sendFrame(16'h96, 16'h69, 8, 16);
    expectOut("afterReset", 8, 16'h96, 16'h69, 1'b1, 1'b0);

    sendFrame(16'($urandom), 16'($urandom), 8, 7);
    sendFrame(16'h5A, 16'hC3, 8, 16);
    expectOut("earlySync", 8, 16'h5A, 16'hC3, 1'b1, 1'b1);

    sendFrame(16'h2, 16'h1, 2, 4);
    expectOut("w2", 2, 16'h2, 16'h1, 1'b1, 1'b0);
    check("w2.err8Sticky", 16'(err8), 16'd1);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        sync = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
      sync = ($urandom_range(0, 23) == 0);
      din  = 1'($urandom);
      @(negedge clk);
    end
    sync = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
